// File: rtl/spu_pkg.sv
// Shared constants and the in-flight result entry for the SPU writeback pipe.
package spu_pkg;

    localparam int unsigned REG_W   = 128;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned MAX_LAT = 7;
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned NUM_SRC = 6;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] rt;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/spu_wb_lane.sv
// One issue lane: latency slot shift register, issue insertion, slot-conflict
// detection and per-source pending-write flags.
module spu_wb_lane
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              inValid,
    input  logic              inWe,
    input  logic [ADDR_W-1:0] inRt,
    input  logic [LAT_W-1:0]  inLat,
    input  logic [REG_W-1:0]  inData,
    input  logic [ADDR_W-1:0] srcAddr [0:NUM_SRC-1],
    output logic [NUM_SRC-1:0] busy,
    output logic              conflict,
    output logic              wbValid,
    output logic              wbWe,
    output logic [ADDR_W-1:0] wbRt,
    output logic [REG_W-1:0]  wbData
);

    wb_entry_t slot [MAX_LAT];
    logic      latOk;
    logic      slotTaken;
    logic      accept;

    // Slot s[L] shifts into s[L-1] at the edge, so it must be free for insertion.
    always_comb begin
        latOk     = 1'b0;
        slotTaken = 1'b0;
        for (int unsigned i = 1; i <= MAX_LAT; i++) begin
            if (32'(inLat) == i) latOk = 1'b1;
        end
        for (int unsigned i = 1; i < MAX_LAT; i++) begin
            if (32'(inLat) == i && slot[i].valid) slotTaken = 1'b1;
        end
        conflict = inValid && !reset && !flush && (!latOk || slotTaken);
        accept   = inValid && !reset && !flush && !conflict;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < MAX_LAT; i++) slot[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < MAX_LAT - 1; i++) slot[i] <= slot[i+1];
            slot[MAX_LAT-1] <= '0;
            for (int unsigned i = 0; i < MAX_LAT; i++) begin
                if (accept && 32'(inLat) == i + 1)
                    slot[i] <= '{valid: 1'b1, we: inWe, rt: inRt, data: inData};
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            for (int unsigned i = 0; i < MAX_LAT; i++) begin
                if (slot[i].valid && slot[i].we && slot[i].rt == srcAddr[s]) busy[s] = 1'b1;
            end
        end
    end

    assign wbValid = slot[0].valid;
    assign wbWe    = slot[0].we;
    assign wbRt    = slot[0].rt;
    assign wbData  = slot[0].data;

endmodule

// File: rtl/spu_writeback_pipe.sv
// Dual-issue SPU register file writer: two latency lanes, same-target
// collision suppression (lane 2 wins) and combined source hazard flags.
module spu_writeback_pipe
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid1,
    input  logic              in_valid2,
    input  logic              in_we1,
    input  logic              in_we2,
    input  logic [ADDR_W-1:0] in_rt1,
    input  logic [ADDR_W-1:0] in_rt2,
    input  logic [LAT_W-1:0]  in_lat1,
    input  logic [LAT_W-1:0]  in_lat2,
    input  logic [REG_W-1:0]  in_data1,
    input  logic [REG_W-1:0]  in_data2,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src_addr [0:NUM_SRC-1],
    output logic [NUM_SRC-1:0] src_busy,
    output logic              conflict1,
    output logic              conflict2,
    output logic [ADDR_W-1:0] readRegisterRT_WB1,
    output logic [ADDR_W-1:0] readRegisterRT_WB2,
    output logic [REG_W-1:0]  writeData_WB1,
    output logic [REG_W-1:0]  writeData_WB2,
    output logic              regWriteEnable_WB1,
    output logic              regWriteEnable_WB2
);

    logic [NUM_SRC-1:0] busy1, busy2;
    logic               wbValid1, wbValid2, wbWe1, wbWe2;
    logic               wrEn1, wrEn2;

    spu_wb_lane lane1 (
        .clk(clk), .reset(reset), .flush(flush),
        .inValid(in_valid1), .inWe(in_we1), .inRt(in_rt1), .inLat(in_lat1), .inData(in_data1),
        .srcAddr(src_addr), .busy(busy1), .conflict(conflict1),
        .wbValid(wbValid1), .wbWe(wbWe1), .wbRt(readRegisterRT_WB1), .wbData(writeData_WB1)
    );

    spu_wb_lane lane2 (
        .clk(clk), .reset(reset), .flush(flush),
        .inValid(in_valid2), .inWe(in_we2), .inRt(in_rt2), .inLat(in_lat2), .inData(in_data2),
        .srcAddr(src_addr), .busy(busy2), .conflict(conflict2),
        .wbValid(wbValid2), .wbWe(wbWe2), .wbRt(readRegisterRT_WB2), .wbData(writeData_WB2)
    );

    assign wrEn1 = wbValid1 && wbWe1;
    assign wrEn2 = wbValid2 && wbWe2;

    // Lane 2 holds the younger instruction, so its write to a shared target survives.
    assign regWriteEnable_WB1 = wrEn1 && !(wrEn2 && readRegisterRT_WB1 == readRegisterRT_WB2);
    assign regWriteEnable_WB2 = wrEn2;
    assign src_busy           = busy1 | busy2;

endmodule

// File: tb/tb_spu_writeback_pipe.sv
// Directed self-checking bench for spu_writeback_pipe.
module tb_spu_writeback_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid1, in_valid2, in_we1, in_we2, flush;
    logic [6:0]   in_rt1, in_rt2;
    logic [2:0]   in_lat1, in_lat2;
    logic [127:0] in_data1, in_data2;
    logic [6:0]   srcAddr [0:5];
    logic [5:0]   src_busy;
    logic         conflict1, conflict2;
    logic [6:0]   rtWb1, rtWb2;
    logic [127:0] dataWb1, dataWb2;
    logic         weWb1, weWb2;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    spu_writeback_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid1(in_valid1), .in_valid2(in_valid2), .in_we1(in_we1), .in_we2(in_we2),
        .in_rt1(in_rt1), .in_rt2(in_rt2), .in_lat1(in_lat1), .in_lat2(in_lat2),
        .in_data1(in_data1), .in_data2(in_data2), .flush(flush), .src_addr(srcAddr),
        .src_busy(src_busy), .conflict1(conflict1), .conflict2(conflict2),
        .readRegisterRT_WB1(rtWb1), .readRegisterRT_WB2(rtWb2),
        .writeData_WB1(dataWb1), .writeData_WB2(dataWb2),
        .regWriteEnable_WB1(weWb1), .regWriteEnable_WB2(weWb2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid1 = 0; in_valid2 = 0; in_we1 = 0; in_we2 = 0; flush = 0;
        in_rt1 = '0; in_rt2 = '0; in_lat1 = '0; in_lat2 = '0;
        in_data1 = '0; in_data2 = '0;
    endtask

    task automatic issue1(input logic [6:0] rt, input logic [2:0] lat, input logic [127:0] d, input logic we);
        in_valid1 = 1; in_we1 = we; in_rt1 = rt; in_lat1 = lat; in_data1 = d;
    endtask

    task automatic issue2(input logic [6:0] rt, input logic [2:0] lat, input logic [127:0] d, input logic we);
        in_valid2 = 1; in_we2 = we; in_rt2 = rt; in_lat2 = lat; in_data2 = d;
    endtask

    task automatic test_reset();
        reset = 1;
        issue1(7'd3, 3'd1, 128'h11, 1);
        issue2(7'd4, 3'd2, 128'h22, 1);
        srcAddr[0] = 7'd3; srcAddr[1] = 7'd4;
        tick(); tick();
        nChecks++;
        if ({weWb1, weWb2} !== 2'b00) begin
            nFails++; $display("FAIL reset_we: got %b expected 00", {weWb1, weWb2});
        end
        nChecks++;
        if (src_busy !== 6'd0) begin
            nFails++; $display("FAIL reset_busy: got %b expected 000000", src_busy);
        end
        reset = 0; idle();
        for (int k = 0; k < 8; k++) begin
            tick();
            nChecks++;
            if ({weWb1, weWb2} !== 2'b00) begin
                nFails++; $display("FAIL reset_late_we cyc %0d: got %b expected 00", k, {weWb1, weWb2});
            end
        end
        // reset in flight: pending L=5 result must never reach WB
        issue1(7'd6, 3'd5, 128'h66, 1);
        tick(); idle(); tick();
        reset = 1; tick(); reset = 0;
        for (int k = 0; k < 8; k++) begin
            nChecks++;
            if (weWb1 !== 1'b0 || src_busy !== 6'd0) begin
                nFails++; $display("FAIL reset_midflight cyc %0d: got we=%b busy=%b expected 0/0", k, weWb1, src_busy);
            end
            tick();
        end
    endtask

    task automatic test_latency();
        issue1(7'd5, 3'd2, {16{8'hA5}}, 1);
        tick(); idle();
        nChecks++;
        if (weWb1 !== 1'b0) begin nFails++; $display("FAIL lat2_early: got %b expected 0", weWb1); end
        tick();
        nChecks++;
        if (weWb1 !== 1'b1 || rtWb1 !== 7'd5 || dataWb1 !== {16{8'hA5}}) begin
            nFails++; $display("FAIL lat2_wb: got we=%b rt=%0d data=%h expected 1/5/%h", weWb1, rtWb1, dataWb1, {16{8'hA5}});
        end
        tick();
        nChecks++;
        if (weWb1 !== 1'b0) begin nFails++; $display("FAIL lat2_after: got %b expected 0", weWb1); end
        issue1(7'd8, 3'd7, 128'h77, 1);
        tick(); idle();
        for (int k = 1; k <= 8; k++) begin
            nChecks++;
            if (weWb1 !== (k == 7)) begin
                nFails++; $display("FAIL lat7 cyc t+%0d: got %b expected %b", k, weWb1, (k == 7));
            end
            if (k == 7) begin
                nChecks++;
                if (rtWb1 !== 7'd8 || dataWb1 !== 128'h77) begin
                    nFails++; $display("FAIL lat7_data: got rt=%0d data=%h expected 8/77", rtWb1, dataWb1);
                end
            end
            tick();
        end
    endtask

    task automatic test_conflict();
        issue1(7'd12, 3'd4, 128'hC1, 1);
        #1;
        nChecks++;
        if (conflict1 !== 1'b0) begin nFails++; $display("FAIL conf_first: got %b expected 0", conflict1); end
        tick();
        issue1(7'd13, 3'd3, 128'hC2, 1);
        #1;
        nChecks++;
        if (conflict1 !== 1'b1) begin nFails++; $display("FAIL conf_slot: got %b expected 1", conflict1); end
        tick(); idle();
        tick();
        nChecks++;
        if (weWb1 !== 1'b0) begin nFails++; $display("FAIL conf_dropped: got %b expected 0", weWb1); end
        tick();
        nChecks++;
        if (weWb1 !== 1'b1 || rtWb1 !== 7'd12 || dataWb1 !== 128'hC1) begin
            nFails++; $display("FAIL conf_kept: got we=%b rt=%0d data=%h expected 1/12/c1", weWb1, rtWb1, dataWb1);
        end
        tick();
        in_lat1 = 3'd0; #1;
        nChecks++;
        if (conflict1 !== 1'b0) begin nFails++; $display("FAIL conf_novalid: got %b expected 0", conflict1); end
        issue1(7'd14, 3'd0, 128'hC3, 1);
        issue2(7'd15, 3'd0, 128'hC4, 1);
        #1;
        nChecks++;
        if ({conflict1, conflict2} !== 2'b11) begin
            nFails++; $display("FAIL conf_lat0: got %b expected 11", {conflict1, conflict2});
        end
        tick(); idle();
        for (int k = 0; k < 8; k++) begin
            nChecks++;
            if ({weWb1, weWb2} !== 2'b00) begin
                nFails++; $display("FAIL conf_lat0_write cyc %0d: got %b expected 00", k, {weWb1, weWb2});
            end
            tick();
        end
    endtask

    task automatic test_collision();
        issue1(7'd9, 3'd3, 128'd1, 1);
        issue2(7'd9, 3'd3, 128'd2, 1);
        #1;
        nChecks++;
        if ({conflict1, conflict2} !== 2'b00) begin
            nFails++; $display("FAIL coll_conflict: got %b expected 00", {conflict1, conflict2});
        end
        tick(); idle(); tick(); tick();
        nChecks++;
        if (weWb1 !== 1'b0 || weWb2 !== 1'b1 || rtWb2 !== 7'd9 || dataWb2 !== 128'd2) begin
            nFails++; $display("FAIL coll_same_rt: got we1=%b we2=%b rt2=%0d data2=%h expected 0/1/9/2", weWb1, weWb2, rtWb2, dataWb2);
        end
        tick();
        issue1(7'd9, 3'd1, 128'd3, 1);
        issue2(7'd10, 3'd1, 128'd4, 1);
        tick(); idle();
        nChecks++;
        if (weWb1 !== 1'b1 || weWb2 !== 1'b1 || dataWb1 !== 128'd3 || dataWb2 !== 128'd4) begin
            nFails++; $display("FAIL coll_diff_rt: got we1=%b we2=%b d1=%h d2=%h expected 1/1/3/4", weWb1, weWb2, dataWb1, dataWb2);
        end
        tick();
    endtask

    task automatic test_hazard();
        for (int s = 0; s < 6; s++) srcAddr[s] = 7'd100;
        srcAddr[3] = 7'd17;
        issue2(7'd17, 3'd6, 128'h17, 1);
        #1;
        nChecks++;
        if (src_busy !== 6'd0) begin nFails++; $display("FAIL haz_issue_cycle: got %b expected 000000", src_busy); end
        tick(); idle();
        for (int k = 1; k <= 7; k++) begin
            nChecks++;
            if (src_busy !== ((k <= 6) ? 6'b001000 : 6'b000000)) begin
                nFails++; $display("FAIL haz_busy t+%0d: got %b expected %b", k, src_busy, (k <= 6) ? 6'b001000 : 6'b000000);
            end
            tick();
        end
        issue2(7'd17, 3'd6, 128'h18, 0);
        tick(); idle();
        for (int k = 1; k <= 7; k++) begin
            nChecks++;
            if (src_busy !== 6'd0 || weWb2 !== 1'b0) begin
                nFails++; $display("FAIL haz_nowe t+%0d: got busy=%b we2=%b expected 0/0", k, src_busy, weWb2);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        issue1(7'd20, 3'd2, 128'h20, 1);
        issue2(7'd21, 3'd5, 128'h21, 1);
        tick(); idle(); tick();
        flush = 1;
        issue1(7'd22, 3'd1, 128'h22, 1);
        #1;
        nChecks++;
        if (conflict1 !== 1'b0) begin nFails++; $display("FAIL flush_conflict: got %b expected 0", conflict1); end
        nChecks++;
        if (weWb1 !== 1'b1 || rtWb1 !== 7'd20 || dataWb1 !== 128'h20) begin
            nFails++; $display("FAIL flush_old_wb: got we=%b rt=%0d data=%h expected 1/20/20", weWb1, rtWb1, dataWb1);
        end
        tick(); idle();
        for (int k = 0; k < 6; k++) begin
            nChecks++;
            if ({weWb1, weWb2} !== 2'b00 || rtWb1 !== 7'd0 || dataWb2 !== 128'd0) begin
                nFails++; $display("FAIL flush_after cyc %0d: got we=%b rt1=%0d d2=%h expected 00/0/0", k, {weWb1, weWb2}, rtWb1, dataWb2);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            issue1(7'(k + 1), 3'd1, 128'(k + 40), 1);
            tick();
            nChecks++;
            if (weWb1 !== 1'b1 || rtWb1 !== 7'(k + 1) || dataWb1 !== 128'(k + 40)) begin
                nFails++; $display("FAIL b2b cyc %0d: got we=%b rt=%0d data=%h expected 1/%0d/%0h", k, weWb1, rtWb1, dataWb1, k + 1, k + 40);
            end
        end
        idle(); tick();
        nChecks++;
        if (weWb1 !== 1'b0) begin nFails++; $display("FAIL b2b_end: got %b expected 0", weWb1); end
    endtask

    initial begin
        idle();
        reset = 0;
        for (int s = 0; s < 6; s++) srcAddr[s] = 7'd0;
        #1;
        test_reset();
        test_latency();
        test_conflict();
        test_collision();
        test_hazard();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
